// File: rtl/bombe_rotor_stepper.sv
// Walks a three-rotor Enigma position triple through every setting, one per divider tick,
// presenting each to the path checker and stopping on the first match or after a full sweep.
module bombe_rotor_stepper #(
  parameter int ALPHABET = 26,
  parameter int TOTAL    = 17576
) (
  input  logic       clk_in,
  input  logic       resetn,
  input  logic       tick_in,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] start_l,
  input  logic [4:0] start_m,
  input  logic [4:0] start_r,
  input  logic       match_valid,
  input  logic       match,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       pos_valid,
  output logic       busy,
  output logic       found,
  output logic       exhausted
);

  localparam logic [4:0]  LAST_POS = 5'(ALPHABET - 1);
  localparam logic [14:0] LAST_CNT = 15'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESENT   = 3'd1,
    S_CHECK     = 3'd2,
    S_WAIT_TICK = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;

  state_t      state_r;
  logic [14:0] cnt_r;
  logic        tick_d_r;
  logic        step_s;
  logic [14:0] next_lmr_s;

  // Out-of-range start positions load as rotor position zero.
  function automatic logic [4:0] clamp_pos(input logic [4:0] v);
    return (v > LAST_POS) ? 5'd0 : v;
  endfunction

  function automatic logic [14:0] advance(input logic [14:0] lmr);
    logic [4:0] l;
    logic [4:0] m;
    logic [4:0] r;
    l = lmr[14:10];
    m = lmr[9:5];
    r = lmr[4:0];
    if (r == LAST_POS) begin
      r = 5'd0;
      if (m == LAST_POS) begin
        m = 5'd0;
        l = (l == LAST_POS) ? 5'd0 : l + 5'd1;
      end else begin
        m = m + 5'd1;
      end
    end else begin
      r = r + 5'd1;
    end
    return {l, m, r};
  endfunction

  // Moore flag encoding {busy, pos_valid, found, exhausted} for a given state.
  function automatic logic [3:0] flags_of(input state_t s);
    case (s)
      S_PRESENT:   return 4'b1100;
      S_CHECK:     return 4'b1000;
      S_WAIT_TICK: return 4'b1000;
      S_FOUND:     return 4'b0010;
      S_EXHAUSTED: return 4'b0001;
      default:     return 4'b0000;
    endcase
  endfunction

  // Rising edge of the divider level is one step request.
  always_comb begin
    step_s     = tick_in & ~tick_d_r;
    next_lmr_s = advance({pos_l, pos_m, pos_r});
  end

  // Sweep sequencer: state, positions, sweep counter and registered flags.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_r                              <= S_IDLE;
      tick_d_r                             <= 1'b1;
      cnt_r                                <= 15'd0;
      pos_l                                <= 5'd0;
      pos_m                                <= 5'd0;
      pos_r                                <= 5'd0;
      {busy, pos_valid, found, exhausted}  <= 4'b0000;
    end else begin
      tick_d_r <= tick_in;
      if (abort) begin
        state_r                             <= S_IDLE;
        {busy, pos_valid, found, exhausted} <= flags_of(S_IDLE);
      end else begin
        case (state_r)
          S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (start) begin
              pos_l                               <= clamp_pos(start_l);
              pos_m                               <= clamp_pos(start_m);
              pos_r                               <= clamp_pos(start_r);
              cnt_r                               <= 15'd0;
              state_r                             <= S_PRESENT;
              {busy, pos_valid, found, exhausted} <= flags_of(S_PRESENT);
            end else begin
              state_r <= state_r;
            end
          end
          S_PRESENT: begin
            state_r                             <= S_CHECK;
            {busy, pos_valid, found, exhausted} <= flags_of(S_CHECK);
          end
          S_CHECK: begin
            if (match_valid) begin
              if (match) begin
                state_r                             <= S_FOUND;
                {busy, pos_valid, found, exhausted} <= flags_of(S_FOUND);
              end else if (cnt_r == LAST_CNT) begin
                state_r                             <= S_EXHAUSTED;
                {busy, pos_valid, found, exhausted} <= flags_of(S_EXHAUSTED);
              end else begin
                state_r                             <= S_WAIT_TICK;
                {busy, pos_valid, found, exhausted} <= flags_of(S_WAIT_TICK);
              end
            end else begin
              state_r <= S_CHECK;
            end
          end
          S_WAIT_TICK: begin
            if (step_s) begin
              {pos_l, pos_m, pos_r}               <= next_lmr_s;
              cnt_r                               <= cnt_r + 15'd1;
              state_r                             <= S_PRESENT;
              {busy, pos_valid, found, exhausted} <= flags_of(S_PRESENT);
            end else begin
              state_r <= S_WAIT_TICK;
            end
          end
          default: begin
            state_r                             <= S_IDLE;
            {busy, pos_valid, found, exhausted} <= flags_of(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Directed bench for bombe_rotor_stepper: expected settings are queued as stimulus is issued
// and a forked monitor checks every pos_valid presentation against the queue.
module tb_bombe_rotor_stepper;

  logic       clk_in;
  logic       resetn;
  logic       tick_in;
  logic       start;
  logic       abort;
  logic [4:0] start_l;
  logic [4:0] start_m;
  logic [4:0] start_r;
  logic       match_valid;
  logic       match;
  logic [4:0] pos_l;
  logic [4:0] pos_m;
  logic [4:0] pos_r;
  logic       pos_valid;
  logic       busy;
  logic       found;
  logic       exhausted;

  int          checks;
  int          errors;
  logic [14:0] exp_q[$];
  logic [14:0] mon_exp;

  bombe_rotor_stepper dut (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .tick_in     (tick_in),
    .start       (start),
    .abort       (abort),
    .start_l     (start_l),
    .start_m     (start_m),
    .start_r     (start_r),
    .match_valid (match_valid),
    .match       (match),
    .pos_l       (pos_l),
    .pos_m       (pos_m),
    .pos_r       (pos_r),
    .pos_valid   (pos_valid),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [18:0] snap();
    return {busy, pos_valid, found, exhausted, pos_l, pos_m, pos_r};
  endfunction

  function automatic logic [18:0] want(input logic [3:0] f, input int l, input int m, input int r);
    return {f, 5'(l), 5'(m), 5'(r)};
  endfunction

  function automatic void push_lmr(input int l, input int m, input int r);
    exp_q.push_back({5'(l), 5'(m), 5'(r)});
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_pv();
    int n;
    n = 0;
    while (!pos_valid && n < 10) begin
      cyc();
      n++;
    end
    if (!pos_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_pv timeout got pos_valid=0 expected 1");
    end
  endtask

  task automatic pulse_start(input int l, input int m, input int r);
    start_l = 5'(l);
    start_m = 5'(m);
    start_r = 5'(r);
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  task automatic respond(input logic m);
    match_valid = 1'b1;
    match       = m;
    cyc();
    match_valid = 1'b0;
    match       = 1'b0;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  // From a PRESENT cycle: move into CHECK and answer.
  task automatic present_and_answer(input logic m);
    wait_pv();
    cyc();
    respond(m);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    resetn      = 1'b0;
    tick_in     = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    start_l     = 5'd0;
    start_m     = 5'd0;
    start_r     = 5'd0;
    match_valid = 1'b0;
    match       = 1'b0;

    fork
      forever begin
        @(negedge clk_in);
        if (pos_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pos_valid_unexpected got %0d,%0d,%0d expected no presentation",
                     pos_l, pos_m, pos_r);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({pos_l, pos_m, pos_r} !== mon_exp) begin
              errors++;
              $display("FAIL setting got %0d,%0d,%0d expected %0d,%0d,%0d", pos_l, pos_m, pos_r,
                       mon_exp[14:10], mon_exp[9:5], mon_exp[4:0]);
            end
          end
        end
      end
    join_none

    repeat (3) cyc();
    chk("reset_outputs", snap(), want(4'b0000, 0, 0, 0));
    resetn = 1'b1;
    repeat (2) cyc();
    tick_in = 1'b0;
    chk("reset_release_tick_high", snap(), want(4'b0000, 0, 0, 0));

    // Start load and first two steps, including the right-rotor carry.
    push_lmr(3, 7, 24);
    pulse_start(3, 7, 24);
    chk("start_flags", snap(), want(4'b1100, 3, 7, 24));
    present_and_answer(1'b0);
    push_lmr(3, 7, 25);
    tick();
    present_and_answer(1'b0);
    push_lmr(3, 8, 0);
    tick();
    present_and_answer(1'b0);
    chk("wait_tick_flags", snap(), want(4'b1000, 3, 8, 0));

    // Abort wins over start in the same cycle; later ticks do nothing.
    start_l = 5'd1;
    start_m = 5'd2;
    start_r = 5'd3;
    abort   = 1'b1;
    start   = 1'b1;
    cyc();
    abort   = 1'b0;
    start   = 1'b0;
    chk("abort_priority", snap(), want(4'b0000, 3, 8, 0));
    tick();
    cyc();
    chk("abort_idle_tick", snap(), want(4'b0000, 3, 8, 0));
    push_lmr(1, 2, 3);
    pulse_start(1, 2, 3);
    chk("restart_after_abort", snap(), want(4'b1100, 1, 2, 3));

    // Tick edge while CHECK is waiting is dropped.
    cyc();
    tick();
    repeat (2) cyc();
    chk("drop_in_check", snap(), want(4'b1000, 1, 2, 3));
    respond(1'b0);
    repeat (3) cyc();
    chk("drop_not_queued", snap(), want(4'b1000, 1, 2, 3));
    push_lmr(1, 2, 4);
    tick();
    wait_pv();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_in_present", snap(), want(4'b0000, 1, 2, 4));

    // Match on the fifth setting.
    for (int i = 0; i < 5; i++) push_lmr(0, 0, i);
    pulse_start(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      present_and_answer(1'b0);
      tick();
    end
    present_and_answer(1'b1);
    chk("found", snap(), want(4'b0010, 0, 0, 4));
    repeat (3) tick();
    respond(1'b1);
    cyc();
    chk("found_hold", snap(), want(4'b0010, 0, 0, 4));

    // Full revolution from 25,25,25 answered with no match everywhere.
    for (int i = 0; i < 17576; i++) begin
      int idx;
      idx = (17575 + i) % 17576;
      push_lmr(idx / 676, (idx / 26) % 26, idx % 26);
    end
    pulse_start(25, 25, 25);
    for (int i = 0; i < 17576; i++) begin
      present_and_answer(1'b0);
      if (i < 17575) tick();
      if (errors > 20) break;
    end
    chk("exhausted", snap(), want(4'b0001, 25, 25, 24));
    exp_q.delete();

    // Out-of-range start values, then asynchronous reset mid-sweep.
    push_lmr(0, 0, 0);
    pulse_start(30, 26, 31);
    chk("start_clamp", snap(), want(4'b1100, 0, 0, 0));
    present_and_answer(1'b0);
    @(posedge clk_in);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset", snap(), want(4'b0000, 0, 0, 0));
    #3;
    resetn = 1'b1;
    repeat (2) cyc();
    chk("post_reset_idle", snap(), want(4'b0000, 0, 0, 0));
    chk("queue_drained", 19'(exp_q.size()), 19'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
